// File: rtl/adc_code_to_decimal.sv
// adc_code_to_decimal: sequential converter from an unsigned converter code
// to a decimal reading (integer ones value plus BCD fraction digits).
// A single restoring shift-subtract divider is reused for every digit. The
// remainder of each division is multiplied by ten and becomes the numerator
// of the next digit.
module adc_code_to_decimal #(
  parameter int DATA_W      = 8,
  parameter int DIVISOR     = 51,
  parameter int FRAC_DIGITS = 2,
  parameter int ONES_W      = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        code,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ONES_W-1:0]        ones_digit,
  output logic [4*FRAC_DIGITS-1:0] frac_digits
);

  // Four extra bits of headroom let the value remainder*10 fit in the
  // datapath, because the remainder is always smaller than DIVISOR.
  localparam int NW = DATA_W + 4;
  localparam int CW = $clog2(NW);
  localparam logic [NW-1:0] DIV_N    = NW'(DIVISOR);
  localparam logic [CW-1:0] CNT_LAST = CW'(NW - 1);
  localparam logic [2:0]    K_LAST   = 3'(FRAC_DIGITS);

  // Parameter legality checks run at elaboration time.
  if (DATA_W < 4 || DATA_W > 16) begin : g_bad_data_w
    $error("adc_code_to_decimal: DATA_W must be 4..16");
  end
  if (DIVISOR < 1 || DIVISOR > (2 ** DATA_W) - 1) begin : g_bad_divisor
    $error("adc_code_to_decimal: DIVISOR must be 1..2^DATA_W-1");
  end
  if (FRAC_DIGITS < 1 || FRAC_DIGITS > 4) begin : g_bad_frac
    $error("adc_code_to_decimal: FRAC_DIGITS must be 1..4");
  end
  if (ONES_W < DATA_W) begin : g_bad_ones_w
    $error("adc_code_to_decimal: ONES_W must be >= DATA_W");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_r;
  state_t                   state_next_s;
  logic                     in_ready_r;
  logic                     out_valid_r;
  logic [NW-1:0]            num_r;
  logic [NW-1:0]            rem_r;
  logic [NW-1:0]            quo_r;
  logic [CW-1:0]            cnt_r;
  logic [2:0]               k_r;
  logic [ONES_W-1:0]        ones_r;
  logic [4*FRAC_DIGITS-1:0] frac_r;

  logic [NW-1:0]            partial_s;
  logic                     ge_s;
  logic [NW-1:0]            diff_s;
  logic [NW-1:0]            quo_s;
  logic [NW-1:0]            rem_x10_s;
  logic                     last_iter_s;

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign ones_digit  = ones_r;
  assign frac_digits = frac_r;

  // One restoring-division step: shift in the next numerator bit, then subtract when the divisor fits.
  always_comb begin
    partial_s   = {rem_r[NW-2:0], num_r[NW-1]};
    ge_s        = (partial_s >= DIV_N);
    diff_s      = ge_s ? (partial_s - DIV_N) : partial_s;
    quo_s       = {quo_r[NW-2:0], ge_s};
    rem_x10_s   = (diff_s << 3) + (diff_s << 1);
    last_iter_s = (cnt_r == {CW{1'b0}});
  end

  // Next-state logic for the IDLE -> DIV -> DONE handshake sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          state_next_s = DIV;
        end else begin
          state_next_s = IDLE;
        end
      end
      DIV: begin
        if (last_iter_s && (k_r == K_LAST)) begin
          state_next_s = DONE;
        end else begin
          state_next_s = DIV;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register; the handshake flags are registered from the next state so that they match it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s == IDLE);
      out_valid_r <= (state_next_s == DONE);
    end
  end

  // Divider datapath: load the code, iterate per digit, and commit each finished digit to the outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      num_r  <= {NW{1'b0}};
      rem_r  <= {NW{1'b0}};
      quo_r  <= {NW{1'b0}};
      cnt_r  <= {CW{1'b0}};
      k_r    <= 3'd0;
      ones_r <= {ONES_W{1'b0}};
      frac_r <= {(4*FRAC_DIGITS){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            num_r <= NW'(code);
            rem_r <= {NW{1'b0}};
            quo_r <= {NW{1'b0}};
            k_r   <= 3'd0;
            cnt_r <= CNT_LAST;
          end
        end
        DIV: begin
          rem_r <= diff_s;
          quo_r <= quo_s;
          num_r <= num_r << 1;
          cnt_r <= cnt_r - 1'b1;
          if (last_iter_s) begin
            if (k_r == 3'd0) begin
              ones_r <= ONES_W'(quo_s);
            end
            for (int i = 0; i < FRAC_DIGITS; i++) begin
              if (k_r == 3'(i + 1)) begin
                frac_r[4*(FRAC_DIGITS-1-i) +: 4] <= quo_s[3:0];
              end
            end
            if (k_r < K_LAST) begin
              num_r <= rem_x10_s;
              rem_r <= {NW{1'b0}};
              quo_r <= {NW{1'b0}};
              k_r   <= k_r + 3'd1;
              cnt_r <= CNT_LAST;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
